// File: rtl/rx_pkg.sv
// Shared widths and pack-FSM state encoding for the RX SPI streamer.
package rx_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned WORD_W   = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PACK = 1'b1
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fall-through read data and word-count output.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      level_q;
  logic             wr_en, rd_en;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem[rptr_q];

  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (rd_en) rptr_q <= rptr_q + 1'b1;
      if (wr_en && !rd_en)      level_q <= level_q + 1'b1;
      else if (rd_en && !wr_en) level_q <= level_q - 1'b1;
    end
  end

endmodule

// File: rtl/rx_spi_streamer.sv
// Packs enabled 16-bit channel samples into 32-bit words, buffers them in a FIFO
// and serialises them MSB first to an external SPI master.
module rx_spi_streamer
  import rx_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DEPTH     = 2048,
  parameter int unsigned PKT_WORDS = 1024
) (
  input  logic                         rx_clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            channels,
  input  logic [SAMPLE_W*NUM_CH-1:0]   ch_data,
  input  logic                         rxstrobe,
  input  logic                         clear_status,
  input  logic                         spi_clk,
  input  logic                         spi_cs,
  output logic                         spi_output,
  output logic                         have_pkt_rdy,
  output logic                         rx_overrun,
  output logic                         rx_underrun,
  output logic [$clog2(DEPTH):0]       fifo_level
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  rx_state_e                   state_q;
  logic [NUM_CH-1:0]           rem_q, rem_a, rem_d;
  logic [SAMPLE_W*NUM_CH-1:0]  data_q;
  logic [WORD_W-1:0]           word_d, wdata_q, rdata, shift_q;
  logic                        push_q, full, empty, pop;
  int                          ia, ib;
  logic                        fa, fb;

  // Pick the two lowest remaining channels; a missing partner pads the upper half with zero.
  always_comb begin
    ia = 0;
    ib = 0;
    fa = 1'b0;
    fb = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rem_q[i] && !fa) begin
        ia = i;
        fa = 1'b1;
      end
    end
    rem_a     = rem_q;
    rem_a[ia] = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rem_a[i] && !fb) begin
        ib = i;
        fb = 1'b1;
      end
    end
    rem_d = rem_a;
    if (fb) rem_d[ib] = 1'b0;
    word_d = {(fb ? data_q[ib*SAMPLE_W +: SAMPLE_W] : {SAMPLE_W{1'b0}}),
              data_q[ia*SAMPLE_W +: SAMPLE_W]};
  end

  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      data_q  <= '0;
      push_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      push_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rxstrobe && (|channels)) begin
            data_q  <= ch_data;
            rem_q   <= channels;
            state_q <= PACK;
          end
        end
        PACK: begin
          push_q  <= 1'b1;
          wdata_q <= word_d;
          rem_q   <= rem_d;
          if (rem_d == '0) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (rx_clk),
    .rst   (reset),
    .push  (push_q),
    .wdata (wdata_q),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // SPI side: [1] is the synchronised level, [2] its previous value for edge detection.
  logic [2:0] sclk_sync, cs_sync;
  logic       sclk_rise, sclk_fall, cs_fall, cs_rise, cs_active, load;
  logic [5:0] bit_cnt_q;

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign cs_fall   = ~cs_sync[1] & cs_sync[2];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];
  assign cs_active = ~cs_sync[1];
  assign load      = cs_fall || (cs_active && sclk_fall && (bit_cnt_q == 6'd32));
  assign pop       = load && !empty;
  assign spi_output = shift_q[WORD_W-1];

  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= 3'b000;
      cs_sync   <= 3'b111;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi_clk};
      cs_sync   <= {cs_sync[1:0], spi_cs};
      if (cs_rise) begin
        shift_q   <= '0;
        bit_cnt_q <= '0;
      end else if (load) begin
        shift_q   <= empty ? '0 : rdata;
        bit_cnt_q <= '0;
      end else if (cs_active) begin
        if (sclk_rise && (bit_cnt_q != 6'd32)) bit_cnt_q <= bit_cnt_q + 1'b1;
        if (sclk_fall && (bit_cnt_q != 6'd0))  shift_q <= shift_q << 1;
      end
    end
  end

  logic ovr_set, und_set;

  // Overrun when a strobe hits a busy packer, or a word meets a full FIFO with no pop.
  assign ovr_set = (rxstrobe && (state_q == PACK)) || (push_q && full && !pop);
  assign und_set = load && empty;

  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      rx_overrun   <= 1'b0;
      rx_underrun  <= 1'b0;
      have_pkt_rdy <= 1'b0;
    end else begin
      if (ovr_set)           rx_overrun <= 1'b1;
      else if (clear_status) rx_overrun <= 1'b0;
      if (und_set)           rx_underrun <= 1'b1;
      else if (clear_status) rx_underrun <= 1'b0;
      have_pkt_rdy <= (fifo_level >= LVL_W'(PKT_WORDS));
    end
  end

endmodule

// File: tb/tb_rx_spi_streamer.sv
// Directed self-checking bench for rx_spi_streamer (small FIFO, SPI at rx_clk/8).
module tb_rx_spi_streamer;

  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned PKT_WORDS = 8;

  logic                 rx_clk = 1'b0;
  logic                 reset, rxstrobe, clear_status, spi_clk, spi_cs;
  logic [NUM_CH-1:0]    channels;
  logic [16*NUM_CH-1:0] ch_data;
  logic                 spi_output, have_pkt_rdy, rx_overrun, rx_underrun;
  logic [4:0]           fifo_level;

  int checks = 0;
  int errors = 0;

  rx_spi_streamer #(
    .NUM_CH    (NUM_CH),
    .DEPTH     (DEPTH),
    .PKT_WORDS (PKT_WORDS)
  ) dut (
    .rx_clk       (rx_clk),
    .reset        (reset),
    .channels     (channels),
    .ch_data      (ch_data),
    .rxstrobe     (rxstrobe),
    .clear_status (clear_status),
    .spi_clk      (spi_clk),
    .spi_cs       (spi_cs),
    .spi_output   (spi_output),
    .have_pkt_rdy (have_pkt_rdy),
    .rx_overrun   (rx_overrun),
    .rx_underrun  (rx_underrun),
    .fifo_level   (fifo_level)
  );

  always #5 rx_clk = ~rx_clk;

  task automatic tick(input int n);
    repeat (n) @(posedge rx_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Strobe is sampled on the next edge; returns 1ns after that edge.
  task automatic strobe();
    rxstrobe = 1'b1;
    tick(1);
    rxstrobe = 1'b0;
  endtask

  task automatic spi_bits(input int n, output logic [31:0] w);
    w = '0;
    for (int b = 0; b < n; b++) begin
      tick(4);
      w = {w[30:0], spi_output};
      spi_clk = 1'b1;
      tick(4);
      spi_clk = 1'b0;
    end
  endtask

  logic [31:0] w;

  initial begin
    reset = 1'b1; rxstrobe = 1'b0; clear_status = 1'b0;
    spi_clk = 1'b0; spi_cs = 1'b1;
    channels = 4'b1111;
    ch_data  = {16'd4, 16'd3, 16'd2, 16'd1};
    tick(2);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_pkt", 32'(have_pkt_rdy), 32'd0);
    chk("rst_ovr", 32'(rx_overrun), 32'd0);
    chk("rst_und", 32'(rx_underrun), 32'd0);
    chk("rst_out", 32'(spi_output), 32'd0);
    reset = 1'b0;
    tick(2);

    // Four channels, check write latency
    strobe();
    tick(1);
    chk("lat_1cyc", 32'(fifo_level), 32'd0);
    tick(1);
    chk("lat_2cyc", 32'(fifo_level), 32'd1);
    tick(1);
    chk("lat_3cyc", 32'(fifo_level), 32'd2);
    tick(3);
    chk("m1111_ovr", 32'(rx_overrun), 32'd0);

    // SPI read of two words then one from an empty FIFO
    spi_cs = 1'b0;
    tick(8);
    spi_bits(32, w);
    chk("spi_w0", w, 32'h0002_0001);
    chk("spi_und_early", 32'(rx_underrun), 32'd0);
    spi_bits(32, w);
    chk("spi_w1", w, 32'h0004_0003);
    spi_bits(32, w);
    chk("spi_w2_empty", w, 32'h0000_0000);
    chk("spi_und", 32'(rx_underrun), 32'd1);
    spi_cs = 1'b1;
    tick(8);
    chk("spi_level0", 32'(fifo_level), 32'd0);
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    chk("und_clear", 32'(rx_underrun), 32'd0);

    // Three channels: last word zero padded
    channels = 4'b0111;
    strobe();
    tick(5);
    chk("m0111_level", 32'(fifo_level), 32'd2);
    spi_cs = 1'b0;
    tick(8);
    spi_bits(32, w);
    chk("m0111_w0", w, 32'h0002_0001);
    spi_bits(32, w);
    chk("m0111_w1", w, 32'h0000_0003);
    spi_cs = 1'b1;
    tick(8);
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;

    // Empty mask is ignored
    channels = 4'b0000;
    strobe();
    tick(5);
    chk("m0_level", 32'(fifo_level), 32'd0);
    chk("m0_ovr", 32'(rx_overrun), 32'd0);

    // Back-to-back strobes: second one dropped
    channels = 4'b1111;
    ch_data  = {16'h9ABC, 16'h5678, 16'h1234, 16'hA5C3};
    strobe();
    strobe();
    tick(5);
    chk("b2b_level", 32'(fifo_level), 32'd2);
    chk("b2b_ovr", 32'(rx_overrun), 32'd1);
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    chk("b2b_clear", 32'(rx_overrun), 32'd0);

    // Abort after 10 bits, then the next word starts from bit 31
    spi_cs = 1'b0;
    tick(8);
    spi_bits(10, w);
    chk("abort_bits", w, 32'h0000_0048);
    tick(4);
    chk("abort_out_mid", 32'(spi_output), 32'd1);
    spi_cs = 1'b1;
    tick(6);
    chk("abort_out_zero", 32'(spi_output), 32'd0);
    tick(4);
    spi_cs = 1'b0;
    tick(8);
    spi_bits(32, w);
    chk("abort_next", w, 32'h9ABC_5678);
    spi_cs = 1'b1;
    tick(8);
    chk("abort_level", 32'(fifo_level), 32'd0);
    chk("abort_und", 32'(rx_underrun), 32'd0);

    // Fill to DEPTH, packet-ready threshold, overflow
    ch_data = {16'd4, 16'd3, 16'd2, 16'd1};
    for (int s = 0; s < 3; s++) begin
      strobe();
      tick(4);
    end
    chk("fill_pkt_lo", 32'(have_pkt_rdy), 32'd0);
    strobe();
    tick(2);
    chk("fill_lvl7", 32'(fifo_level), 32'd7);
    tick(1);
    chk("fill_lvl8", 32'(fifo_level), 32'd8);
    chk("fill_pkt_lag", 32'(have_pkt_rdy), 32'd0);
    tick(1);
    chk("fill_pkt_hi", 32'(have_pkt_rdy), 32'd1);
    for (int s = 0; s < 4; s++) begin
      strobe();
      tick(4);
    end
    chk("fill_full", 32'(fifo_level), 32'd16);
    chk("fill_ovr_none", 32'(rx_overrun), 32'd0);
    strobe();
    tick(5);
    chk("over_level", 32'(fifo_level), 32'd16);
    chk("over_ovr", 32'(rx_overrun), 32'd1);

    // Reset mid-PACK from a full FIFO with flags set
    strobe();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(4);
    chk("rstp_level", 32'(fifo_level), 32'd0);
    chk("rstp_ovr", 32'(rx_overrun), 32'd0);
    chk("rstp_pkt", 32'(have_pkt_rdy), 32'd0);
    chk("rstp_und", 32'(rx_underrun), 32'd0);
    // Reset with the first word queued but not yet written
    strobe();
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(4);
    chk("rstp2_level", 32'(fifo_level), 32'd0);
    chk("rstp2_out", 32'(spi_output), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_spi_streamer.md
RX_SPI_STREAMER -- requirements
Module: rx_spi_streamer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of 16-bit input channels (even, 2..8).
REQ-002 SHALL have parameter DEPTH, default 2048, FIFO depth in 32-bit words (power of two).
REQ-003 SHALL have parameter PKT_WORDS, default 1024, packet-ready threshold in words (1..DEPTH).
REQ-004 SHALL have port rx_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port channels  in  NUM_CH  channel enable mask, bit i enables channel i.
REQ-007 SHALL have port ch_data  in  16*NUM_CH  channel samples, channel i at bits [16i+15:16i].
REQ-008 SHALL have port rxstrobe  in  1  one-cycle pulse marking a valid sample set.
REQ-009 SHALL have port clear_status  in  1  clears sticky flags.
REQ-010 SHALL have ports spi_clk in 1, spi_cs in 1 (active low): asynchronous SPI master inputs.
REQ-011 SHALL have port spi_output  out  1  serial data, MSB first.
REQ-012 SHALL have ports have_pkt_rdy, rx_overrun, rx_underrun  out  1 each  status.
REQ-013 SHALL have port fifo_level  out  $clog2(DEPTH)+1  current FIFO word count.

Function
REQ-014 SHALL, on rxstrobe in IDLE with a non-zero mask, latch ch_data and channels, then enter PACK.
REQ-015 SHALL, in PACK, emit one 32-bit word per cycle: enabled channels ascending, earlier channel in bits [15:0], later in [31:16].
REQ-016 SHALL zero-pad bits [31:16] of the last word when the enabled count is odd, then return to IDLE.
REQ-017 SHALL ignore rxstrobe when the mask is all zero (no write, no flag).
REQ-018 SHALL drop an rxstrobe arriving while in PACK and set rx_overrun.
REQ-019 SHALL drop any word written while the FIFO is full, set rx_overrun, and continue packing.
REQ-020 SHALL pass each sample set in ceil(enabled/2) PACK cycles, first word written 2 cycles after rxstrobe.
REQ-021 SHALL synchronise spi_clk and spi_cs with two flops each and detect edges in the rx_clk domain; spi_clk SHALL be <= rx_clk/4.
REQ-022 SHALL, on synchronised spi_cs falling, pop one FIFO word into the 32-bit shift register, or load zero and set rx_underrun if the FIFO is empty.
REQ-023 SHALL update spi_output on synchronised spi_clk falling edges and count bits on rising edges.
REQ-024 SHALL, after the 32nd rising edge, pop and load the next word on the following falling edge, with the same empty rule.
REQ-025 SHALL, on spi_cs rising mid-word, discard the partial word, clear the bit counter and hold spi_output at 0.
REQ-026 SHALL keep fifo_level unchanged on a simultaneous push and pop, including while full.
REQ-027 SHALL register have_pkt_rdy = (fifo_level >= PKT_WORDS), one cycle after the level change.
REQ-028 SHALL hold rx_overrun and rx_underrun sticky until clear_status; a set event in the same cycle wins over clear.

Reset
REQ-029 SHALL on reset clear the FIFO pointers, fifo_level, the bit counter and the shift register, force the FSM to IDLE, and drive spi_output, have_pkt_rdy, rx_overrun and rx_underrun to 0.
REQ-030 SHALL abandon any in-progress PACK or SPI word on reset without writing a partial word.

Structure
REQ-031 SHALL take SAMPLE_W=16, WORD_W=32 and the FSM state enum (IDLE, PACK) from shared package rx_pkg.
REQ-032 SHALL implement storage as one sub-module sync_fifo (parameters WIDTH, DEPTH; push, pop, full, empty, level).

Verification
REQ-033 SHALL cover: mask 4'b1111, ch0..3=1,2,3,4, one strobe -> words 0x00020001, 0x00040003.
REQ-034 SHALL cover: mask 4'b0111 -> words 0x00020001, 0x00000003; mask 0 -> no write.
REQ-035 SHALL cover: a second strobe 1 cycle after the first with mask 4'b1111 -> one set only, rx_overrun=1; clear_status -> 0.
REQ-036 SHALL cover: fill to DEPTH with no reads, plus one more strobe -> fifo_level=DEPTH, rx_overrun=1; have_pkt_rdy rises when level reaches PKT_WORDS.
REQ-037 SHALL cover: SPI read of 64 bits at rx_clk/8 from 2 stored words -> bitstreams match MSB first; a third word with FIFO empty -> zeros and rx_underrun=1.
REQ-038 SHALL cover: spi_cs deasserted after 10 bits, then reasserted -> next FIFO word sent from bit 31; reset mid-PACK -> fifo_level=0 and all flags 0.
